// File: rtl/mult_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_share_pkg
// Description : Shared types and helpers for the shared-multiplier arbiter:
//               requester-ID width calculation and the tag record that
//               travels alongside each multiplier operation.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_share_pkg;

  // Widest requester ID any legal configuration needs (up to 8 requesters)
  localparam int c_MAX_ID_W = 3;

  // Requester-index width; never narrower than one bit
  function automatic int calc_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One tag pipeline stage: valid flag plus owning requester index
  typedef struct packed {
    logic                  valid;
    logic [c_MAX_ID_W-1:0] id;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Purely combinational round-robin arbiter. Searches from
//               i_last+1 upward (modulo NUM_REQ) and grants the first
//               asserted request. Reusable by any shared-resource controller.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = calc_id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [ID_W-1:0] w_cand;

  // Walk the rotated priority order; the first hit owns the grant
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_W'((int'(i_last) + k) % NUM_REQ);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_share_arbiter
// Description : Shares one pipelined multiplier between NUM_REQ requesters.
//               Round-robin issue onto m_a/m_b, a tag pipeline matched to
//               MULT_LATENCY that returns each product with its requester
//               ID, and global back-pressure through the multiplier enable.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int WIDTH_A      = 8,
  parameter  int WIDTH_B      = 8,
  parameter  int MULT_LATENCY = 2,
  localparam int ID_W         = calc_id_w(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH_A-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH_B-1:0]   req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [WIDTH_A+WIDTH_B-1:0]   rsp_p,
  output logic [ID_W+1:0]              inflight,
  output logic                         m_ce,
  output logic [WIDTH_A-1:0]           m_a,
  output logic [WIDTH_B-1:0]           m_b,
  input  logic [WIDTH_A+WIDTH_B-1:0]   m_p
);

  localparam logic [ID_W+1:0] c_ONE       = (ID_W+2)'(1);
  localparam logic [ID_W-1:0] c_LAST_INIT = ID_W'(NUM_REQ - 1);

  logic                 w_adv;
  logic                 w_issue;
  logic                 w_accept;
  logic                 w_any;
  logic [NUM_REQ-1:0]   w_grant;
  logic [ID_W-1:0]      w_gidx;
  logic [ID_W-1:0]      r_last;
  logic [ID_W+1:0]      r_inflight;
  logic [WIDTH_A-1:0]   w_a_arr [NUM_REQ];
  logic [WIDTH_B-1:0]   w_b_arr [NUM_REQ];
  tag_t                 r_tag   [MULT_LATENCY];
  logic                 w_tag_unused;

  // Split the packed operand buses into per-requester slices
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a_arr[gi] = req_a[gi*WIDTH_A +: WIDTH_A];
    assign w_b_arr[gi] = req_b[gi*WIDTH_B +: WIDTH_B];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  // The whole pipeline (multiplier plus tags) moves only when the output
  // slot is empty or being drained this cycle
  assign w_adv     = ~rsp_valid | rsp_ready;
  assign m_ce      = w_adv;
  assign req_ready = {NUM_REQ{w_adv}} & w_grant;
  assign w_issue   = w_adv & w_any;
  assign w_accept  = rsp_valid & rsp_ready;

  // Idle issue slots feed zeros so the multiplier sees quiet operands
  assign m_a = w_issue ? w_a_arr[w_gidx] : '0;
  assign m_b = w_issue ? w_b_arr[w_gidx] : '0;

  assign rsp_valid    = r_tag[MULT_LATENCY-1].valid;
  assign rsp_id       = r_tag[MULT_LATENCY-1].id[ID_W-1:0];
  assign rsp_p        = m_p;
  assign inflight     = r_inflight;
  // Upper id bits stay zero when fewer than the maximum requesters exist
  assign w_tag_unused = &{1'b0, r_tag[MULT_LATENCY-1].id};

  // Round-robin pointer remembers the most recent winner
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= c_LAST_INIT;
    end else if (w_issue) begin
      r_last <= w_gidx;
    end
  end

  // Tag shift register tracks ownership in lockstep with the multiplier
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MULT_LATENCY; i++) begin
        r_tag[i] <= '0;
      end
    end else if (w_adv) begin
      r_tag[0].valid <= w_issue;
      r_tag[0].id    <= w_issue ? c_MAX_ID_W'(w_gidx) : '0;
      for (int i = 1; i < MULT_LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Count operations issued but not yet taken on the response port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_accept})
        2'b10:   r_inflight <= r_inflight + c_ONE;
        2'b01:   r_inflight <= r_inflight - c_ONE;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_share_arbiter
// Description : Self-checking bench for mult_share_arbiter with a behavioural
//               pipelined signed multiplier attached. Directed stimulus pushes
//               hand-computed products into a queue; a monitor pops and
//               compares on every accepted response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_share_arbiter;

  localparam int NREQ = 4;
  localparam int WA   = 8;
  localparam int WB   = 8;
  localparam int LAT  = 2;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*WA-1:0]   req_a;
  logic [NREQ*WB-1:0]   req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [WA+WB-1:0]     rsp_p;
  logic [IDW+1:0]       inflight;
  logic                 m_ce;
  logic [WA-1:0]        m_a;
  logic [WB-1:0]        m_b;
  logic [WA+WB-1:0]     m_p;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [15:0]    p;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(
    .NUM_REQ      (NREQ),
    .WIDTH_A      (WA),
    .WIDTH_B      (WB),
    .MULT_LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .inflight  (inflight),
    .m_ce      (m_ce),
    .m_a       (m_a),
    .m_b       (m_b),
    .m_p       (m_p)
  );

  // Behavioural pipelined two's-complement multiplier, frozen while m_ce low
  logic signed [15:0] sa, sb, sprod;
  logic [15:0]        r_mp [LAT];
  assign sa    = {{8{m_a[7]}}, m_a};
  assign sb    = {{8{m_b[7]}}, m_b};
  assign sprod = sa * sb;
  assign m_p   = r_mp[LAT-1];

  always @(posedge clk) begin
    if (m_ce) begin
      r_mp[0] <= sprod;
      for (int i = 1; i < LAT; i++) r_mp[i] <= r_mp[i-1];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every accepted response must match the queue head
  always @(negedge clk) begin
    if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual id=%0d p=0x%0h required=none", rsp_id, rsp_p);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        check("rsp_p", 32'(rsp_p), 32'(mon_e.p));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*WA +: WA] = a;
    req_b[i*WB +: WB] = b;
  endtask

  task automatic do_reset();
    tick();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    rst       = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && exp_q.size() != 0; n++) tick();
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) tick();
  endtask

  // Hard time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_m_ce", 32'(m_ce), 32'd1);
    check("rst_m_a", 32'(m_a), 32'd0);
    check("rst_m_b", 32'(m_b), 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);

    // Single request: 7 * -3 = -21
    tick();
    set_op(2, 8'd7, 8'hFD);
    req_valid = 4'b0100;
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'h4);
    check("t1_m_a", 32'(m_a), 32'h07);
    check("t1_m_b", 32'(m_b), 32'hFD);
    exp_q.push_back('{id: 2'd2, p: 16'hFFEB});
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t1_valid_cyc1", 32'(rsp_valid), 32'd0);
    check("t1_inflight_cyc1", 32'(inflight), 32'd1);
    tick();
    @(negedge clk);
    check("t1_valid_cyc2", 32'(rsp_valid), 32'd1);
    check("t1_inflight_cyc2", 32'(inflight), 32'd1);
    tick();
    @(negedge clk);
    check("t1_inflight_cyc3", 32'(inflight), 32'd0);
    check("t1_valid_cyc3", 32'(rsp_valid), 32'd0);

    // All requesters saturated: grants 0,1,2,3,0
    do_reset();
    set_op(0, 8'd1, 8'd1);
    set_op(1, 8'd2, 8'd2);
    set_op(2, 8'd3, 8'd3);
    set_op(3, 8'd4, 8'd4);
    req_valid = 4'b1111;
    @(negedge clk); check("t2_grant0", 32'(req_ready), 32'h1); exp_q.push_back('{id: 2'd0, p: 16'd1});  tick();
    @(negedge clk); check("t2_grant1", 32'(req_ready), 32'h2); exp_q.push_back('{id: 2'd1, p: 16'd4});  tick();
    @(negedge clk); check("t2_grant2", 32'(req_ready), 32'h4); exp_q.push_back('{id: 2'd2, p: 16'd9});  tick();
    @(negedge clk); check("t2_grant3", 32'(req_ready), 32'h8); exp_q.push_back('{id: 2'd3, p: 16'd16}); tick();
    @(negedge clk); check("t2_grant4", 32'(req_ready), 32'h1); exp_q.push_back('{id: 2'd0, p: 16'd1});  tick();
    req_valid = '0;
    drain();

    // Back-pressure on a product for id 1 (5*6=30) with requester 3 waiting
    set_op(1, 8'd5, 8'd6);
    req_valid = 4'b0010;
    @(negedge clk);
    check("t3_ready", 32'(req_ready), 32'h2);
    exp_q.push_back('{id: 2'd1, p: 16'd30});
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("t3_pre_valid", 32'(rsp_valid), 32'd0);
    tick();
    set_op(3, 8'd2, 8'd3);
    req_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_stall_valid", 32'(rsp_valid), 32'd1);
      check("t3_stall_id", 32'(rsp_id), 32'd1);
      check("t3_stall_p", 32'(rsp_p), 32'd30);
      check("t3_stall_m_ce", 32'(m_ce), 32'd0);
      check("t3_stall_ready", 32'(req_ready), 32'd0);
      check("t3_stall_inflight", 32'(inflight), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t3_release_ready", 32'(req_ready), 32'h8);
    check("t3_release_inflight", 32'(inflight), 32'd1);
    exp_q.push_back('{id: 2'd3, p: 16'd6});
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t3_after_inflight", 32'(inflight), 32'd1);
    drain();

    // Continuous single requester: inflight saturates at 2
    set_op(0, 8'd3, 8'd5);
    req_valid = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t4_ready", 32'(req_ready), 32'h1);
      check("t4_inflight", 32'(inflight), (k < 2) ? 32'(k) : 32'd2);
      exp_q.push_back('{id: 2'd0, p: 16'd15});
      tick();
    end
    req_valid = '0;
    drain();

    // Reset with two operations in flight; discarded products must not appear
    set_op(0, 8'd2, 8'd2);
    req_valid = 4'b0001;
    @(negedge clk); check("t5_issue_a", 32'(req_ready), 32'h1); tick();
    @(negedge clk); check("t5_issue_b", 32'(req_ready), 32'h1); tick();
    req_valid = '0;
    rst       = 1'b1;
    @(negedge clk);
    check("t5_inflight_at_rst", 32'(inflight), 32'd2);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_post_inflight", 32'(inflight), 32'd0);
    check("t5_post_valid0", 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    check("t5_post_valid1", 32'(rsp_valid), 32'd0);
    tick();
    // Boundary operands with requesters 0 and 3 competing after reset
    set_op(0, 8'h80, 8'h80);
    set_op(3, 8'h7F, 8'h80);
    req_valid = 4'b1001;
    @(negedge clk);
    check("t5_first_grant", 32'(req_ready), 32'h1);
    exp_q.push_back('{id: 2'd0, p: 16'h4000});
    tick();
    @(negedge clk);
    check("t5_second_grant", 32'(req_ready), 32'h8);
    exp_q.push_back('{id: 2'd3, p: 16'hC080});
    tick();
    req_valid = '0;
    drain();

    check("final_inflight", 32'(inflight), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
